// File: rtl/fifo_pkg.sv
// Shared defaults and pointer sizing for the single-clock FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 32'd8;
  localparam int unsigned FIFO_DEPTH_DEF = 32'd8;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write and clear, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [WIDTH-1:0]  mem_wdata,
  input  logic [ADDR_W-1:0] mem_raddr,
  output logic [WIDTH-1:0]  mem_rdata
);

  logic [WIDTH-1:0] mem_d [0:DEPTH-1];
  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  // Next-state of the array: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (mem_we) begin
      mem_d[mem_waddr] = mem_wdata;
    end else begin
      mem_d[mem_waddr] = mem_q[mem_waddr];
    end
  end

  // Storage register with synchronous clear so reads never return X.
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign mem_rdata = mem_q[mem_raddr];

endmodule

// File: rtl/async_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and flags taken straight from them.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  input  logic                  fifo_wen,
  input  logic [FIFO_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_full,
  input  logic                  fifo_ren,
  output logic [FIFO_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_empty
);

  localparam int unsigned PTR_W  = ptr_width(FIFO_DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 32'd1;

  logic [PTR_W-1:0] wptr_d, wptr_q;
  logic [PTR_W-1:0] rptr_d, rptr_q;
  logic             wr_accept_s;
  logic             rd_accept_s;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                      (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);

  // Acceptance uses the pre-edge flags, so a write at full is refused even alongside a read.
  always_comb begin
    wr_accept_s = fifo_wen & ~fifo_full;
    rd_accept_s = fifo_ren & ~fifo_empty;
    if (wr_accept_s) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_accept_s) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer registers; reset overrides any request in the same cycle.
  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_mem #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .mem_clk   (fifo_clk),
    .mem_rst   (fifo_rst),
    .mem_we    (wr_accept_s),
    .mem_waddr (wptr_q[ADDR_W-1:0]),
    .mem_wdata (fifo_wdata),
    .mem_raddr (rptr_q[ADDR_W-1:0]),
    .mem_rdata (fifo_rdata)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo with a queue scoreboard of accepted writes.
module tb_async_fifo;

  logic       fifo_clk = 1'b0;
  logic       fifo_rst = 1'b1;
  logic       fifo_wen = 1'b0;
  logic [7:0] fifo_wdata = 8'h00;
  logic       fifo_full;
  logic       fifo_ren = 1'b0;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;

  int         vectors = 0;
  int         miscompares = 0;
  int         popped = 0;
  logic [7:0] sb_q[$];

  async_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(8)) dut (
    .fifo_clk   (fifo_clk),
    .fifo_rst   (fifo_rst),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty)
  );

  always #5 fifo_clk = ~fifo_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive, check pre-edge outputs, clock, update the model.
  task automatic cycle(input logic wen, input logic [7:0] wd, input logic ren, output logic wacc);
    logic ra;
    fifo_wen   = wen;
    fifo_wdata = wd;
    fifo_ren   = ren;
    #1;
    chk("empty", {31'd0, fifo_empty}, {31'd0, sb_q.size() == 0});
    chk("full", {31'd0, fifo_full}, {31'd0, sb_q.size() == 8});
    wacc = wen && (sb_q.size() < 8);
    ra   = ren && (sb_q.size() > 0);
    if (ra) chk("rdata", {24'd0, fifo_rdata}, {24'd0, sb_q[0]});
    @(posedge fifo_clk);
    #1;
    if (ra) begin
      void'(sb_q.pop_front());
      popped++;
    end
    if (wacc) sb_q.push_back(wd);
    fifo_wen = 1'b0;
    fifo_ren = 1'b0;
  endtask

  task automatic do_reset(input int n);
    fifo_rst = 1'b1;
    fifo_wen = 1'b0;
    fifo_ren = 1'b0;
    repeat (n) @(posedge fifo_clk);
    #1;
    fifo_rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    logic       acc;
    logic [7:0] ctr;
    int         c;

    // Reset held for four cycles
    do_reset(4);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_rdata", {24'd0, fifo_rdata}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, acc);
    chk("idle_rdata", {24'd0, fifo_rdata}, 32'd0);

    // Fill to full, then an overflow write
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0, acc);
      if (i == 0) chk("first_not_empty", {31'd0, fifo_empty}, 32'd0);
    end
    chk("fill_full", {31'd0, fifo_full}, 32'd1);
    cycle(1'b1, 8'h08, 1'b0, acc);
    chk("ovf_ignored", {31'd0, acc}, 32'd0);
    chk("ovf_head", {24'd0, fifo_rdata}, 32'd0);

    // Drain in order, then an underflow read
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, acc);
      if (i == 0) chk("full_drops", {31'd0, fifo_full}, 32'd0);
    end
    chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1, acc);
    chk("udf_empty", {31'd0, fifo_empty}, 32'd1);

    // Streaming with pointer wrap: 2 writes per 5 cycles, reads 2 of 3 cycles
    ctr = 8'h00;
    popped = 0;
    c = 0;
    while (popped < 100 && c < 2000) begin
      cycle((c % 5 == 0) || (c % 5 == 2), ctr, (c % 3) != 1, acc);
      if (acc) ctr++;
      c++;
    end
    chk("stream_done", {31'd0, popped >= 100}, 32'd1);
    c = 0;
    while (sb_q.size() > 0 && c < 20) begin
      cycle(1'b0, 8'h00, 1'b1, acc);
      c++;
    end

    // Simultaneous read/write at occupancy 4
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, acc);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b1, acc);
    chk("rw_occ_empty", {31'd0, fifo_empty}, 32'd0);
    chk("rw_occ_full", {31'd0, fifo_full}, 32'd0);
    chk("rw_head", {24'd0, fifo_rdata}, 32'hB0);

    // At full, write+read only pops
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, acc);
    chk("rw_full", {31'd0, fifo_full}, 32'd1);
    cycle(1'b1, 8'hEE, 1'b1, acc);
    chk("rw_full_wrej", {31'd0, acc}, 32'd0);
    chk("rw_full_after", {31'd0, fifo_full}, 32'd0);
    c = 0;
    while (sb_q.size() > 0 && c < 20) begin
      cycle(1'b0, 8'h00, 1'b1, acc);
      c++;
    end

    // Reset mid-operation discards contents
    cycle(1'b1, 8'h11, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b0, acc);
    cycle(1'b1, 8'h33, 1'b0, acc);
    do_reset(1);
    chk("mrst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("mrst_rdata", {24'd0, fifo_rdata}, 32'd0);
    cycle(1'b1, 8'h44, 1'b0, acc);
    chk("mrst_next", {24'd0, fifo_rdata}, 32'h44);
    cycle(1'b0, 8'h00, 1'b1, acc);
    chk("mrst_final_empty", {31'd0, fifo_empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Parameterised first-in/first-out data buffer with independent write and read handshake ports.
- Writer pushes words while the FIFO is not full; reader pops them in the same order while it is not empty.
- Used as a generic elastic buffer between a producer and a consumer in the same clock domain.
- Provides first-word-fall-through read data plus registered full and empty status flags.

Parameters:
- FIFO_WIDTH, 8, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of storage entries; must be a power of two and >=2.

Ports:
- fifo_clk  input  1  single clock; all state updates on the rising edge.
- fifo_rst  input  1  synchronous, active-high reset, sampled on the rising edge of fifo_clk.
- fifo_wen  input  1  write request.
- fifo_wdata  input  FIFO_WIDTH  write data.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- fifo_ren  input  1  read request (pop).
- fifo_rdata  output  FIFO_WIDTH  head-of-queue data.
- fifo_empty  output  1  FIFO holds zero words.

Behaviour:
- Interface: one clock, fifo_clk; reset fifo_rst is synchronous and active-high.
- Storage: FIFO_DEPTH x FIFO_WIDTH array.
- Pointers: write and read pointers, each clog2(FIFO_DEPTH)+1 bits wide. The extra MSB is a wrap bit.
- Reset values (on a rising edge with fifo_rst=1):
  - both pointers = 0
  - fifo_empty = 1, fifo_full = 0
  - all storage entries = 0, so fifo_rdata = 0
- Reset has priority over wen/ren; reset mid-operation discards all contents.
- Accepted write (fifo_wen=1 and fifo_full=0): mem[wptr low bits] <= fifo_wdata; wptr increments by 1 at the rising edge.
- Accepted read (fifo_ren=1 and fifo_empty=0): rptr increments by 1 at the rising edge.
- Read data, first-word-fall-through:
  - fifo_rdata = mem[rptr low bits], combinational from storage.
  - When not empty it always shows the oldest unread word, so the value presented while fifo_ren=1 is the word consumed at that edge.
  - When empty it shows the stale entry at rptr; this value is don't-care.
- Latency: a word written at edge N is visible on fifo_rdata, with fifo_empty=0, after edge N.
- Flags, derived from the pointers (pointer registers feed them directly, no extra pipeline):
  - fifo_empty = (wptr == rptr)
  - fifo_full = (low bits equal) and (MSBs differ)
- Overflow: fifo_wen while full is ignored; there is no storage or pointer change.
- Underflow: fifo_ren while empty is ignored.
- Simultaneous accepted write and read: both pointers advance; occupancy is unchanged; flags are unchanged.
- When full, a write in the same cycle as a read is still rejected. Acceptance is decided on the pre-edge flag only.
- Wrap-around: pointers roll over modulo 2*FIFO_DEPTH; the address uses the low bits only.
- No X propagation on outputs after reset.

Decomposition:
- Shared package fifo_pkg:
  - default width/depth constants
  - pointer-width localparam helper (clog2(DEPTH)+1)
- One sub-module: fifo_mem.
  - Simple dual-port array: synchronous write, asynchronous read, synchronous clear on fifo_rst.
  - Instantiated by async_fifo; pointer and flag logic stays in the top.

Test Plan:
- Reset check: hold fifo_rst=1 for 4 cycles, then release -> fifo_empty=1, fifo_full=0, fifo_rdata=0x00; wen=0 and ren=0 leave the state unchanged.
- Fill: write 0x00..0x07 on consecutive cycles, ren=0 -> fifo_empty deasserts after the first edge; fifo_full=1 after the 8th edge; a 9th write of 0x08 is ignored.
- Drain: from full, ren=1 for 8 cycles -> fifo_rdata shows 0x00..0x07 in order; fifo_full drops after the first pop; fifo_empty=1 after the 8th; an extra ren causes no change.
- Streaming with wrap: write an incrementing counter whenever not full (one write per 2.5 cycles average); read whenever not empty, for 100 words -> every popped word equals the expected counter value; pointers wrap several times; zero mismatches.
- Simultaneous read/write at occupancy 4 -> occupancy stays 4, flags unchanged, order preserved. At full with wen=ren=1 -> only the pop occurs; fifo_full=0 afterwards.
- Reset mid-operation: after writing 0x11, 0x22, 0x33, assert fifo_rst for 1 cycle -> fifo_empty=1, fifo_rdata=0x00; the next write of 0x44 is the next word read.
